// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: the ALU and MEM writeback handshakes, the pipeline stall, and the registered regfile write port.
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              stall;
  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_addr;
  logic [DATA_W-1:0] alu_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_src;
  modport master (
    output stall, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, wr_en, wr_addr, wr_data, wr_src
  );
  modport slave (
    input  stall, alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, wr_en, wr_addr, wr_data, wr_src
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin ALU/MEM writeback arbiter driving one registered regfile write port.
// Define REGWR_XZR_FILTER_EN to suppress the write strobe for transfers that target X31.
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input logic clk,
  input logic reset,
  regfile_write_arbiter_if.slave bus
);
  logic              alu_gnt, mem_gnt, xfer;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              wr_en_d, wr_en_q;
  logic [ADDR_W-1:0] wr_addr_d, wr_addr_q;
  logic [DATA_W-1:0] wr_data_d, wr_data_q;
  logic              wr_src_d, wr_src_q;
  // last_grant: 0=ALU, 1=MEM; the source that did not win last takes a tie
  logic              last_grant_d, last_grant_q;
  always_comb begin
    alu_gnt      = ~bus.stall & bus.alu_valid & (~bus.mem_valid | last_grant_q);
    mem_gnt      = ~bus.stall & bus.mem_valid & (~bus.alu_valid | ~last_grant_q);
    xfer         = alu_gnt | mem_gnt;
    sel_addr     = mem_gnt ? bus.mem_addr : bus.alu_addr;
    sel_data     = mem_gnt ? bus.mem_data : bus.alu_data;
`ifdef REGWR_XZR_FILTER_EN
    wr_en_d      = xfer & (sel_addr != {ADDR_W{1'b1}});
`else
    wr_en_d      = xfer;
`endif
    wr_addr_d    = xfer ? sel_addr : wr_addr_q;
    wr_data_d    = xfer ? sel_data : wr_data_q;
    wr_src_d     = xfer ? mem_gnt : wr_src_q;
    last_grant_d = xfer ? mem_gnt : last_grant_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_src_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_src_q     <= wr_src_d;
      last_grant_q <= last_grant_d;
    end
  end
  assign bus.alu_ready = alu_gnt;
  assign bus.mem_ready = mem_gnt;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.wr_src    = wr_src_q;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vectors with hand-computed expectations for regfile_write_arbiter.
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  regfile_write_arbiter_if #(.DATA_W(64), .ADDR_W(5)) bus ();
  regfile_write_arbiter #(.DATA_W(64), .ADDR_W(5)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    bus.stall = 1'b0;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
    bus.alu_addr = '0;
    bus.mem_addr = '0;
    bus.alu_data = '0;
    bus.mem_data = '0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1;
    step();
    reset = 1'b0;
  endtask
  initial begin
    idle();
    step();
    step();
    reset = 1'b0;
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_wr_src", bus.wr_src, 0);
    chk("idle_alu_ready", bus.alu_ready, 0);
    chk("idle_mem_ready", bus.mem_ready, 0);
    bus.alu_valid = 1'b1;
    bus.alu_addr = 5'd3;
    bus.alu_data = 64'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("alu_only_ready%0d", i), bus.alu_ready, 1);
      chk($sformatf("alu_only_mem_ready%0d", i), bus.mem_ready, 0);
      step();
      chk($sformatf("alu_only_wr_en%0d", i), bus.wr_en, 1);
      chk($sformatf("alu_only_wr_addr%0d", i), bus.wr_addr, 3);
      chk($sformatf("alu_only_wr_data%0d", i), bus.wr_data, 64'hDEAD_BEEF);
      chk($sformatf("alu_only_wr_src%0d", i), bus.wr_src, 0);
    end
    reset = 1'b1;
    #1;
    chk("midrst_wr_en", bus.wr_en, 0);
    idle();
    step();
    reset = 1'b0;
    step();
    chk("post_rst_wr_en", bus.wr_en, 0);
    chk("post_rst_wr_addr", bus.wr_addr, 0);
    chk("post_rst_wr_data", bus.wr_data, 0);
    chk("post_rst_wr_src", bus.wr_src, 0);
    bus.alu_valid = 1'b1;
    bus.alu_addr = 5'd5;
    bus.alu_data = 64'h11;
    bus.mem_valid = 1'b1;
    bus.mem_addr = 5'd7;
    bus.mem_data = 64'h22;
    for (int i = 0; i < 4; i++) begin
      logic m;
      m = (i % 2 == 1);
      #1;
      chk($sformatf("rr_alu_ready%0d", i), bus.alu_ready, !m);
      chk($sformatf("rr_mem_ready%0d", i), bus.mem_ready, m);
      step();
      chk($sformatf("rr_wr_en%0d", i), bus.wr_en, 1);
      chk($sformatf("rr_wr_src%0d", i), bus.wr_src, m);
      chk($sformatf("rr_wr_addr%0d", i), bus.wr_addr, m ? 7 : 5);
      chk($sformatf("rr_wr_data%0d", i), bus.wr_data, m ? 64'h22 : 64'h11);
    end
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("stall_alu_ready%0d", i), bus.alu_ready, 0);
      chk($sformatf("stall_mem_ready%0d", i), bus.mem_ready, 0);
      step();
      chk($sformatf("stall_wr_en%0d", i), bus.wr_en, 0);
      chk($sformatf("stall_wr_src_hold%0d", i), bus.wr_src, 1);
      chk($sformatf("stall_wr_addr_hold%0d", i), bus.wr_addr, 7);
    end
    bus.stall = 1'b0;
    #1;
    chk("unstall_alu_ready", bus.alu_ready, 1);
    chk("unstall_mem_ready", bus.mem_ready, 0);
    step();
    chk("unstall_wr_en", bus.wr_en, 1);
    chk("unstall_wr_src", bus.wr_src, 0);
    idle();
    do_reset();
    bus.alu_valid = 1'b1;
    bus.alu_addr = 5'd9;
    bus.alu_data = 64'hA;
    bus.mem_valid = 1'b1;
    bus.mem_addr = 5'd9;
    bus.mem_data = 64'hB;
    #1;
    chk("same_addr_alu_ready", bus.alu_ready, 1);
    chk("same_addr_mem_ready0", bus.mem_ready, 0);
    step();
    chk("same_addr_w1_data", bus.wr_data, 64'hA);
    chk("same_addr_w1_addr", bus.wr_addr, 9);
    bus.alu_valid = 1'b0;
    #1;
    chk("same_addr_mem_ready1", bus.mem_ready, 1);
    step();
    chk("same_addr_w2_en", bus.wr_en, 1);
    chk("same_addr_w2_addr", bus.wr_addr, 9);
    chk("same_addr_w2_src", bus.wr_src, 1);
    bus.mem_valid = 1'b0;
    step();
    chk("same_addr_final_en", bus.wr_en, 0);
    chk("same_addr_final_data", bus.wr_data, 64'hB);
    bus.mem_valid = 1'b1;
    bus.mem_addr = 5'd31;
    bus.mem_data = 64'h5;
    #1;
    chk("xzr_mem_ready", bus.mem_ready, 1);
    step();
    bus.mem_valid = 1'b0;
`ifdef REGWR_XZR_FILTER_EN
    chk("xzr_wr_en", bus.wr_en, 0);
`else
    chk("xzr_wr_en", bus.wr_en, 1);
`endif
    chk("xzr_wr_addr", bus.wr_addr, 31);
    chk("xzr_wr_data", bus.wr_data, 64'h5);
    step();
    chk("xzr_after_wr_en", bus.wr_en, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
